// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-image loader.
// State encoding, sync byte default and data widths.
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ROM_SIZE_DEF = 128;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// UART byte input, instruction RAM write port and CPU status of the loader.
// master = loader side, slave = UART/RAM/CPU side.
interface instr_loader_if;
  import loader_pkg::*;

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    input  rx_data, rx_valid,
    output mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

  modport slave (
    output rx_data, rx_valid,
    input  mem_we, mem_addr, mem_wdata, cpu_hold, done, error
  );

endinterface

// File: rtl/loader_word_pack.sv
// Packs bytes MSB-first into a 32-bit word; word/word_ready are combinational
// on the 4th byte so the caller can register the write in the same cycle.
module loader_word_pack
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic [WORD_W-1:0] word,
  output logic              word_ready
);

  logic [WORD_W-1:0] sr;
  logic [1:0]        idx;

  assign word       = {sr[WORD_W-BYTE_W-1:0], byte_dat};
  assign word_ready = byte_vld && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sr  <= '0;
      idx <= 2'd0;
    end else if (byte_vld) begin
      sr  <= word;
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a framed program image from the UART into instruction RAM, holding the CPU until done.
// Checksum byte and CHECK state exist only when LOADER_CHECKSUM_EN is defined.
module instr_loader
  import loader_pkg::*;
#(
  parameter int                ROM_SIZE  = ROM_SIZE_DEF,
  parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  instr_loader_if.master bus
);

  state_t            state, state_n;
  logic [BYTE_W-1:0] cnt_hi;
  logic [15:0]       count, words;
  logic [WORD_W-1:0] wr_ptr;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [WORD_W-1:0] pack_word;
  logic              pack_ready;
  logic [15:0]       cnt_full;
  logic              is_sync, last_word;

`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_DATA = CHECK;
  logic [BYTE_W-1:0] acc;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  assign cnt_full  = {cnt_hi, bus.rx_data};
  assign is_sync   = (bus.rx_data == SYNC_BYTE);
  assign last_word = pack_ready && ((words + 16'd1) == count);

  loader_word_pack u_pack (
    .clk        (clk),
    .reset      (reset),
    .clear      (state_n == CNT_HI),
    .byte_vld   (bus.rx_valid && (state == DATA)),
    .byte_dat   (bus.rx_data),
    .word       (pack_word),
    .word_ready (pack_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (bus.rx_valid) begin
      case (state)
        IDLE, DONE, ERROR: if (is_sync) state_n = CNT_HI;
        CNT_HI:            state_n = CNT_LO;
        CNT_LO: begin
          if (cnt_full > 16'(ROM_SIZE)) state_n = ERROR;
          else if (cnt_full == 16'd0)   state_n = AFTER_DATA;
          else                          state_n = DATA;
        end
        DATA:              if (last_word) state_n = AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
        CHECK:             state_n = (bus.rx_data == acc) ? DONE : ERROR;
`endif
        default:           state_n = state;
      endcase
    end
  end

  // Write pointer and accumulator restart on every accepted sync byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_hi  <= '0;
      count   <= '0;
      words   <= '0;
      wr_ptr  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      acc     <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (is_sync) begin
              words  <= '0;
              wr_ptr <= '0;
`ifdef LOADER_CHECKSUM_EN
              acc    <= '0;
`endif
            end
          end
          CNT_HI: cnt_hi <= bus.rx_data;
          CNT_LO: count  <= cnt_full;
          DATA: begin
`ifdef LOADER_CHECKSUM_EN
            acc <= acc ^ bus.rx_data;
`endif
            if (pack_ready) begin
              we_q    <= 1'b1;
              addr_q  <= wr_ptr;
              wdata_q <= pack_word;
              wr_ptr  <= wr_ptr + 32'd4;
              words   <= words + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done      = (state == DONE);
  assign bus.error     = (state == ERROR);
  assign bus.cpu_hold  = (state != DONE);

endmodule
